// File: rtl/fetch_decode_pipe.sv
// IF/ID pipeline stage: DEPTH-entry in-order buffer with valid/ready handshakes on both sides.
// A branch or jump flush empties the stage, and a bubble is driven on the outputs while it is empty.
module fetch_decode_pipe #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [XLEN-1:0] NOP_INST = '0,
    parameter int unsigned     CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            b_taken,
    input  logic            jmp,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] Inst,
    input  logic [XLEN-1:0] PC,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_Inst,
    output logic [XLEN-1:0] out_PC,
    output logic [CW-1:0]   occupancy,
    output logic            flush_drop
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("fetch_decode_pipe: DEPTH must be in 1..8");
    end

    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          flush_drop_q, flush_drop_d;
    logic          flush, push, pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign flush     = b_taken | jmp;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        flush_drop_d = flush & ((count_q != '0) | (in_valid & in_ready));
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flush_drop_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flush_drop_q <= flush_drop_d;
        end
    end

    // Storage carries no reset; the outputs are masked whenever the stage is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= Inst;
            pc_mem[wr_ptr_q]   <= PC;
        end
    end

    assign out_Inst   = out_valid ? inst_mem[rd_ptr_q] : NOP_INST;
    assign out_PC     = out_valid ? pc_mem[rd_ptr_q] : '0;
    assign occupancy  = count_q;
    assign flush_drop = flush_drop_q;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Bench for fetch_decode_pipe: DEPTH=2 and DEPTH=3 instances share their inputs and are
// checked every cycle against queue-based models, with directed literal checks and a random phase.
module tb_fetch_decode_pipe;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned DEP [2] = '{2, 3};

    logic        clk = 1'b0;
    logic        reset;
    logic        b_taken, jmp, in_valid, out_ready;
    logic [31:0] Inst, PC;

    logic        in_ready_w  [2];
    logic        out_valid_w [2];
    logic [31:0] out_inst_w  [2];
    logic [31:0] out_pc_w    [2];
    logic [1:0]  occ_w       [2];
    logic        fd_w        [2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue of {inst, pc} per instance plus the expected flush_drop.
    logic [63:0] mq [2][$];
    logic        mfd [2];

    always #5 clk = ~clk;

    fetch_decode_pipe #(.XLEN(32), .DEPTH(2), .NOP_INST(NOP)) dut2 (
        .clk(clk), .reset(reset), .b_taken(b_taken), .jmp(jmp),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .Inst(Inst), .PC(PC),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_Inst(out_inst_w[0]),
        .out_PC(out_pc_w[0]), .occupancy(occ_w[0]), .flush_drop(fd_w[0])
    );

    fetch_decode_pipe #(.XLEN(32), .DEPTH(3), .NOP_INST(NOP)) dut3 (
        .clk(clk), .reset(reset), .b_taken(b_taken), .jmp(jmp),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .Inst(Inst), .PC(PC),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_Inst(out_inst_w[1]),
        .out_PC(out_pc_w[1]), .occupancy(occ_w[1]), .flush_drop(fd_w[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mq[k].delete();
                mfd[k] = 1'b0;
            end else begin
                automatic int  sz  = mq[k].size();
                automatic bit  fl  = b_taken | jmp;
                automatic bit  rdy = (sz < int'(DEP[k]));
                mfd[k] = fl && (sz != 0 || (in_valid && rdy));
                if (fl) begin
                    mq[k].delete();
                end else begin
                    if (sz != 0 && out_ready) void'(mq[k].pop_front());
                    if (in_valid && rdy) mq[k].push_back({Inst, PC});
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            automatic bit          ev = (mq[k].size() != 0);
            automatic logic [63:0] hd = ev ? mq[k][0] : {NOP, 32'h0};
            chk($sformatf("d%0d out_valid", DEP[k]), 64'(out_valid_w[k]), 64'(ev));
            chk($sformatf("d%0d in_ready", DEP[k]), 64'(in_ready_w[k]),
                64'(mq[k].size() < int'(DEP[k])));
            chk($sformatf("d%0d out_Inst", DEP[k]), 64'(out_inst_w[k]), 64'(hd[63:32]));
            chk($sformatf("d%0d out_PC", DEP[k]), 64'(out_pc_w[k]), 64'(hd[31:0]));
            chk($sformatf("d%0d occupancy", DEP[k]), 64'(occ_w[k]), 64'(mq[k].size()));
            chk($sformatf("d%0d flush_drop", DEP[k]), 64'(fd_w[k]), 64'(mfd[k]));
        end
    end

    task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic bt, input logic jp);
        in_valid  = iv;
        Inst      = iv ? inst : 'x;
        PC        = iv ? pc : 'x;
        out_ready = ordy;
        b_taken   = bt;
        jmp       = jp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; b_taken = 1'b0; jmp = 1'b0;
        Inst = '0; PC = '0;
        #2;
        chk("reset out_valid", 64'(out_valid_w[0]), 64'd0);
        chk("reset out_Inst", 64'(out_inst_w[0]), 64'(NOP));
        chk("reset in_ready", 64'(in_ready_w[0]), 64'd1);
        chk("reset occupancy", 64'(occ_w[0]), 64'd0);
        #1 reset = 1'b0;

        // First push, then pop it.
        step(1'b1, 32'h00A0_0093, 32'h100, 1'b0, 1'b0, 1'b0);
        chk("push1 out_valid", 64'(out_valid_w[0]), 64'd1);
        chk("push1 out_Inst", 64'(out_inst_w[0]), 64'h00A0_0093);
        chk("push1 out_PC", 64'(out_pc_w[0]), 64'h100);
        chk("push1 occupancy", 64'(occ_w[0]), 64'd1);
        chk("push1 in_ready", 64'(in_ready_w[0]), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("pop1 out_PC", 64'(out_pc_w[0]), 64'h0);

        // Fill DEPTH=2, hold a third beat while full.
        step(1'b1, 32'h11, 32'h104, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 32'h108, 1'b0, 1'b0, 1'b0);
        chk("full occupancy", 64'(occ_w[0]), 64'd2);
        chk("full in_ready", 64'(in_ready_w[0]), 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h33, 32'h10C, 1'b0, 1'b0, 1'b0);
        chk("held occupancy", 64'(occ_w[0]), 64'd2);
        chk("held out_PC", 64'(out_pc_w[0]), 64'h104);
        step(1'b1, 32'h33, 32'h10C, 1'b1, 1'b0, 1'b0);
        chk("pop full out_PC", 64'(out_pc_w[0]), 64'h108);
        chk("pop full occupancy", 64'(occ_w[0]), 64'd1);
        step(1'b1, 32'h33, 32'h10C, 1'b0, 1'b0, 1'b0);
        chk("late accept occupancy", 64'(occ_w[0]), 64'd2);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain out_PC", 64'(out_pc_w[0]), 64'h10C);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drained out_Inst", 64'(out_inst_w[0]), 64'(NOP));

        // Flush with an empty DEPTH=2 stage, both requests asserted.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("empty flush flush_drop", 64'(fd_w[0]), 64'd0);
        chk("empty flush occupancy", 64'(occ_w[0]), 64'd0);
        step(1'b1, 32'h44, 32'h110, 1'b0, 1'b0, 1'b0);
        chk("resume occupancy", 64'(occ_w[0]), 64'd1);
        chk("resume out_PC", 64'(out_pc_w[0]), 64'h110);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming: one-cycle latency, occupancy steady at 1.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            chk("stream out_PC", 64'(out_pc_w[1]), 64'(32'h200 + 32'(4 * i)));
            chk("stream occupancy", 64'(occ_w[0]), 64'd1);
        end

        // Flush with two entries and an offered beat.
        step(1'b1, 32'h77, 32'h250, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h66, 32'h300, 1'b1, 1'b1, 1'b0);
        chk("flush out_valid", 64'(out_valid_w[0]), 64'd0);
        chk("flush out_PC", 64'(out_pc_w[0]), 64'h0);
        chk("flush flush_drop", 64'(fd_w[0]), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("flush_drop pulse", 64'(fd_w[0]), 64'd0);

        // Async reset between edges.
        step(1'b1, 32'h88, 32'h400, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h99, 32'h404, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async reset out_valid", 64'(out_valid_w[0]), 64'd0);
        chk("async reset occupancy", 64'(occ_w[1]), 64'd0);
        #3 reset = 1'b0;
        #1;

        // Random traffic, occasional flushes.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom, $urandom, ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
        end

        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
